// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, opcode field placement and next-PC select encoding for the fetch slice
package fetch_pkg;
  localparam int DEF_PC_W = 10;
  localparam int DEF_INSTR_W = 16;
  localparam int OPCODE_W = 6;
  localparam int DEF_STACK_DEPTH = 4;
  typedef enum logic [1:0] {NPC_INC, NPC_TGT, NPC_CALL, NPC_RET} npc_sel_e;
  function automatic int opcode_msb(input int instr_w);
    return instr_w - 1;
  endfunction
  function automatic int opcode_lsb(input int instr_w);
    return instr_w - OPCODE_W;
  endfunction
endpackage

// File: rtl/ret_stack.sv
// ret_stack: LIFO of return addresses; push ignored when full, pop ignored when empty
module ret_stack
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEF_STACK_DEPTH,
  parameter int W = DEF_PC_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] ONE = 1;
  logic [AW:0] cnt;
  logic [W-1:0] mem [DEPTH];
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[cnt[AW-1:0] - ONE];
  // occupancy counter; pop wins if both are requested
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (pop && !empty) cnt <= cnt - 1'b1;
    else if (push && !full) cnt <= cnt + 1'b1;
  // entry storage needs no reset: slots above the occupancy are never read
  always_ff @(posedge clk)
    if (push && !full && !pop) mem[cnt[AW-1:0]] <= din;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter with next-PC selection; return stack and flags only with FETCH_RET_STACK_EN
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pc_en,
  input  logic               s_inc,
  input  logic               call,
  input  logic               ret,
  input  logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic [OPCODE_W-1:0] opcode,
  output logic [PC_W-1:0]    target,
  output logic               stk_ovf,
  output logic               stk_unf
);
  logic [PC_W-1:0] pc_inc, next_pc, top;
  npc_sel_e sel;
  assign opcode = instr[opcode_msb(INSTR_W):opcode_lsb(INSTR_W)];
  assign target = instr[PC_W-1:0];
  assign pc_inc = pc + 1'b1;
`ifdef FETCH_RET_STACK_EN
  logic full, empty, ovf_q, unf_q;
  ret_stack #(.DEPTH(STACK_DEPTH), .W(PC_W)) u_stack (
    .clk(clk), .reset_n(reset_n),
    .push(pc_en && call && !ret), .pop(pc_en && ret),
    .din(pc_inc), .dout(top), .full(full), .empty(empty)
  );
  // ret beats call beats target/increment; ret on empty falls through to pc+1
  always_comb begin
    sel = ret ? (empty ? NPC_INC : NPC_RET) : call ? NPC_CALL : s_inc ? NPC_INC : NPC_TGT;
  end
  // sticky misuse flags, only updated on enabled cycles
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (pc_en) begin
      if (ret && empty) unf_q <= 1'b1;
      if (call && !ret && full) ovf_q <= 1'b1;
    end
  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;
`else
  localparam int unused_depth = STACK_DEPTH;
  logic unused_ctl;
  assign unused_ctl = call ^ ret;
  assign top = '0;
  // without a stack, only the sequencing bit chooses the next PC
  always_comb begin
    sel = s_inc ? NPC_INC : NPC_TGT;
  end
  assign stk_ovf = 1'b0;
  assign stk_unf = 1'b0;
`endif
  assign next_pc = sel == NPC_RET ? top : sel == NPC_INC ? pc_inc : target;
  // program counter advances only when enabled
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) pc <= '0;
    else if (pc_en) pc <= next_pc;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of PC sequencing, wrap, jumps, reset and (when built in) the return stack
module tb_fetch_unit;
  logic clk = 0, reset_n = 0, pc_en = 0, s_inc = 0, call = 0, ret = 0;
  logic [15:0] instr = '0;
  logic [9:0] pc, target;
  logic [5:0] opcode;
  logic stk_ovf, stk_unf;
  int n_vec = 0, n_bad = 0;

  fetch_unit dut (
    .clk(clk), .reset_n(reset_n), .pc_en(pc_en), .s_inc(s_inc), .call(call), .ret(ret),
    .instr(instr), .pc(pc), .opcode(opcode), .target(target), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic en, input logic si, input logic c, input logic r, input logic [9:0] tgt);
    pc_en = en; s_inc = si; call = c; ret = r; instr = {6'h2A, tgt};
    @(posedge clk); #1;
  endtask

  task automatic flags(input string tag, input logic o, input logic u);
    chk({tag, "_ovf"}, {31'd0, stk_ovf}, {31'd0, o});
    chk({tag, "_unf"}, {31'd0, stk_unf}, {31'd0, u});
  endtask

  initial begin
    #12;
    chk("rst_pc", {22'd0, pc}, 32'd0);
    flags("rst", 1'b0, 1'b0);
    reset_n = 1;
    for (int i = 1; i <= 5; i++) begin
      step(1, 1, 0, 0, 10'h000);
      chk($sformatf("seq%0d", i), {22'd0, pc}, i);
    end
    #3 reset_n = 0;
    #1 chk("async_rst", {22'd0, pc}, 32'd0);
    #2 reset_n = 1;
    step(1, 1, 0, 0, 10'h000);
    chk("post_rst", {22'd0, pc}, 32'd1);
    instr = {6'h15, 10'h2C3};
    #1;
    chk("opcode", {26'd0, opcode}, 32'h15);
    chk("target", {22'd0, target}, 32'h2C3);
    step(1, 0, 0, 0, 10'h3FF);
    chk("jmp_max", {22'd0, pc}, 32'h3FF);
    step(1, 1, 0, 0, 10'h000);
    chk("wrap", {22'd0, pc}, 32'h000);
    flags("wrap", 1'b0, 1'b0);
    step(1, 0, 0, 0, 10'h155);
    chk("jmp155", {22'd0, pc}, 32'h155);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 10'h200);
      chk($sformatf("hold%0d", i), {22'd0, pc}, 32'h155);
    end
    flags("hold", 1'b0, 1'b0);
`ifdef FETCH_RET_STACK_EN
    step(1, 0, 0, 0, 10'h010);
    step(1, 1, 1, 0, 10'h100);
    chk("call100", {22'd0, pc}, 32'h100);
    step(1, 1, 0, 1, 10'h000);
    chk("ret011", {22'd0, pc}, 32'h011);
    step(1, 1, 1, 0, 10'h050);
    chk("call050", {22'd0, pc}, 32'h050);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, i[0], 10'h0F0);
      chk($sformatf("hold_call%0d", i), {22'd0, pc}, 32'h050);
    end
    step(1, 1, 1, 1, 10'h0F0);
    chk("callret", {22'd0, pc}, 32'h012);
    flags("callret", 1'b0, 1'b0);
    step(1, 1, 1, 0, 10'h020);
    step(1, 1, 1, 0, 10'h030);
    step(1, 1, 1, 0, 10'h040);
    step(1, 1, 1, 0, 10'h050);
    flags("full", 1'b0, 1'b0);
    step(1, 1, 1, 0, 10'h060);
    chk("call5", {22'd0, pc}, 32'h060);
    flags("ovf", 1'b1, 1'b0);
    step(1, 1, 0, 1, 10'h000);
    chk("pop1", {22'd0, pc}, 32'h041);
    step(1, 1, 0, 1, 10'h000);
    chk("pop2", {22'd0, pc}, 32'h031);
    step(1, 1, 0, 1, 10'h000);
    chk("pop3", {22'd0, pc}, 32'h021);
    step(1, 1, 0, 1, 10'h000);
    chk("pop4", {22'd0, pc}, 32'h013);
    flags("pop4", 1'b1, 1'b0);
    step(1, 0, 0, 1, 10'h3AA);
    chk("unf_pc", {22'd0, pc}, 32'h014);
    flags("unf", 1'b1, 1'b1);
    step(1, 0, 0, 0, 10'h222);
    flags("sticky", 1'b1, 1'b1);
`else
    step(1, 1, 1, 0, 10'h0AA);
    chk("nostk_call", {22'd0, pc}, 32'h156);
    step(1, 1, 0, 1, 10'h0AA);
    chk("nostk_ret", {22'd0, pc}, 32'h157);
    step(1, 0, 1, 1, 10'h0AA);
    chk("nostk_tgt", {22'd0, pc}, 32'h0AA);
    flags("nostk", 1'b0, 1'b0);
`endif
    #2 reset_n = 0;
    #1;
    chk("final_rst_pc", {22'd0, pc}, 32'd0);
    flags("final_rst", 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
